// File: rtl/instr_fetch_unit.sv
// Instruction fetch sequencer: owns the PC, runs a req/rdy handshake to
// instruction memory, issues one instruction at a time to the decoder and
// applies redirects from execute. Fetch stops for good once a HLT issues.
//
// state  | meaning
// -------+------------------------------------------------------------------
// FETCH  | request outstanding at pc (req low only in the first post-reset cycle)
// ISSUE  | instruction held on instr/opcode/instr_pc until consumed (stall=0)
// HALT   | HLT consumed; no further requests until reset
// DROP   | redirected while a request was pending; wait out the old word,
//        | discard it, then fetch from the saved target
module instr_fetch_unit #(
   parameter int                ADDR_W     = 16,
   parameter int                INSTR_W    = 16,
   parameter logic [ADDR_W-1:0] RESET_PC   = '0,
   parameter logic [3:0]        HLT_OPCODE = 4'hF
) (
   input  logic               clk,
   input  logic               rst_n,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic               imem_rdy,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic               instr_vld,
   output logic [INSTR_W-1:0] instr,
   output logic [3:0]         opcode,
   output logic [ADDR_W-1:0]  instr_pc,
   output logic [ADDR_W-1:0]  pc_plus1,
   input  logic               stall,
   input  logic               redirect,
   input  logic [ADDR_W-1:0]  redirect_pc,
   output logic               halted
);

   localparam logic [1:0] ST_FETCH = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_HALT  = 2'd2;
   localparam logic [1:0] ST_DROP  = 2'd3;

   logic [1:0]        state;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] dropTarget;

   assign imem_addr = pc;
   assign opcode    = instr[INSTR_W-1 -: 4];

   // Fetch sequencer: state, PC, memory request and the issued-instruction registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_FETCH;
         pc         <= RESET_PC;
         dropTarget <= RESET_PC;
         imem_req   <= 1'b0;
         instr_vld  <= 1'b0;
         instr      <= '0;
         instr_pc   <= '0;
         pc_plus1   <= ADDR_W'(1);
         halted     <= 1'b0;
      end else begin
         case (state)
            ST_FETCH: begin
               if (redirect) begin
                  // A word already requested but not yet returned must still be
                  // collected, so park the target and drain it in DROP.
                  if (imem_req && !imem_rdy) begin
                     state      <= ST_DROP;
                     dropTarget <= redirect_pc;
                  end else begin
                     pc <= redirect_pc;
                  end
                  imem_req <= 1'b1;
               end else if (imem_req && imem_rdy) begin
                  instr     <= imem_rdata;
                  instr_pc  <= pc;
                  pc_plus1  <= pc + ADDR_W'(1);
                  pc        <= pc + ADDR_W'(1);
                  instr_vld <= 1'b1;
                  imem_req  <= 1'b0;
                  state     <= ST_ISSUE;
               end else begin
                  imem_req <= 1'b1;
               end
            end
            ST_ISSUE: begin
               if (redirect) begin
                  instr_vld <= 1'b0;
                  pc        <= redirect_pc;
                  imem_req  <= 1'b1;
                  state     <= ST_FETCH;
               end else if (!stall) begin
                  instr_vld <= 1'b0;
                  if (instr[INSTR_W-1 -: 4] == HLT_OPCODE) begin
                     halted <= 1'b1;
                     state  <= ST_HALT;
                  end else begin
                     imem_req <= 1'b1;
                     state    <= ST_FETCH;
                  end
               end
            end
            ST_DROP: begin
               if (imem_rdy) begin
                  pc    <= redirect ? redirect_pc : dropTarget;
                  state <= ST_FETCH;
               end else if (redirect) begin
                  dropTarget <= redirect_pc;
               end
            end
            default: begin
               // HALT: hold everything; only reset leaves.
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: a memory responder with fixed or random latency,
// directed scenarios with exact cycle timing, and a randomized run checked
// against a transaction-level model of the expected PC stream.
module tb_instr_fetch_unit;

   logic        clk;
   logic        rst_n;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_rdy;
   logic [15:0] imem_rdata;
   logic        instr_vld;
   logic [15:0] instr;
   logic [3:0]  opcode;
   logic [15:0] instr_pc;
   logic [15:0] pc_plus1;
   logic        stall;
   logic        redirect;
   logic [15:0] redirect_pc;
   logic        halted;

   logic [15:0] mem [0:65535];
   int          memLat;
   logic        memRand;
   int          waitCnt;
   int          errors;
   int          checks;

   instr_fetch_unit dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_rdy    (imem_rdy),
      .imem_rdata  (imem_rdata),
      .instr_vld   (instr_vld),
      .instr       (instr),
      .opcode      (opcode),
      .instr_pc    (instr_pc),
      .pc_plus1    (pc_plus1),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .halted      (halted)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Memory responder: decides rdy just after each falling edge for the next rising edge.
   initial begin
      imem_rdy   = 1'b0;
      imem_rdata = '0;
      waitCnt    = 0;
      forever begin
         @(negedge clk);
         #1;
         if (imem_req) begin
            if (memRand ? ($urandom_range(0, 2) == 0) : (waitCnt >= memLat)) begin
               imem_rdy   = 1'b1;
               imem_rdata = mem[imem_addr];
               waitCnt    = 0;
            end else begin
               imem_rdy   = 1'b0;
               imem_rdata = 16'($urandom);
               waitCnt++;
            end
         end else begin
            imem_rdy   = 1'b0;
            imem_rdata = 16'($urandom);
            waitCnt    = 0;
         end
      end
   end

   task automatic doReset();
      stall       = 1'b0;
      redirect    = 1'b0;
      redirect_pc = '0;
      rst_n       = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      memRand = 1'b0;
      memLat  = 0;
      rst_n   = 1'b0;
      #3;
      checks++;
      if (imem_req !== 1'b0 || instr_vld !== 1'b0 || instr !== 16'h0 || opcode !== 4'h0 ||
          instr_pc !== 16'h0 || halted !== 1'b0 || imem_addr !== 16'h0) begin
         errors++;
         $display("FAIL reset_values: req=%b vld=%b instr=%h op=%h ipc=%h halted=%b addr=%h, expected all zero",
                  imem_req, instr_vld, instr, opcode, instr_pc, halted, imem_addr);
      end
      doReset();
      @(negedge clk);
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 16'h0) begin
         errors++;
         $display("FAIL reset_first_req: req=%b addr=%h, expected req=1 addr=0000", imem_req, imem_addr);
      end
   endtask

   task automatic test_random();
      logic [15:0] expPc, heldWord, heldPc, prevAddr;
      logic        held, prevReq, stV, rdV;
      int          idle;
      for (int i = 0; i < 65536; i++) mem[i] = {4'($urandom_range(0, 14)), 12'($urandom)};
      memRand = 1'b1;
      doReset();
      expPc = 16'h0; held = 1'b0; prevReq = 1'b0; prevAddr = '0; idle = 0;
      heldWord = '0; heldPc = '0;
      for (int c = 0; c < 2000; c++) begin
         @(negedge clk);
         if (prevReq && !imem_rdy) begin
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== prevAddr || instr_vld !== 1'b0) begin
               errors++;
               $display("FAIL rand_req_stable: req=%b addr=%h vld=%b, expected req=1 addr=%h vld=0",
                        imem_req, imem_addr, instr_vld, prevAddr);
            end
         end
         if (instr_vld && !held) begin
            checks++;
            if (instr !== mem[expPc] || instr_pc !== expPc || opcode !== mem[expPc][15:12] ||
                pc_plus1 !== expPc + 16'd1) begin
               errors++;
               $display("FAIL rand_issue: instr=%h ipc=%h op=%h p1=%h, expected instr=%h ipc=%h op=%h p1=%h",
                        instr, instr_pc, opcode, pc_plus1, mem[expPc], expPc, mem[expPc][15:12], expPc + 16'd1);
            end
            held = 1'b1; heldWord = mem[expPc]; heldPc = expPc; idle = 0;
         end else if (held) begin
            checks++;
            if (instr_vld !== 1'b1 || instr !== heldWord || instr_pc !== heldPc) begin
               errors++;
               $display("FAIL rand_hold: vld=%b instr=%h ipc=%h, expected vld=1 instr=%h ipc=%h",
                        instr_vld, instr, instr_pc, heldWord, heldPc);
            end
         end
         checks++;
         if (halted !== 1'b0) begin
            errors++;
            $display("FAIL rand_halted: halted=%b, expected 0", halted);
         end
         idle++;
         if (idle > 100) begin
            errors++;
            $display("FAIL rand_liveness: no issue for %0d cycles, expected progress", idle);
            break;
         end
         prevReq  = imem_req;
         prevAddr = imem_addr;
         stV = ($urandom_range(0, 3) == 0);
         rdV = ($urandom_range(0, 11) == 0);
         stall       = stV;
         redirect    = rdV;
         redirect_pc = 16'($urandom);
         if (rdV) begin
            expPc = redirect_pc; held = 1'b0; idle = 0;
         end else if (instr_vld && !stV) begin
            expPc = expPc + 16'd1; held = 1'b0;
         end
      end
      stall = 1'b0; redirect = 1'b0; memRand = 1'b0;
   endtask

   task automatic test_program();
      logic [3:0] ops [4];
      ops[0] = 4'h0; ops[1] = 4'h2; ops[2] = 4'h8; ops[3] = 4'hF;
      mem[0] = 16'h0123; mem[1] = 16'h2456; mem[2] = 16'h8789; mem[3] = 16'hF000;
      memLat = 0;
      doReset();
      for (int c = 1; c <= 14; c++) begin
         @(negedge clk);
         checks++;
         if (c <= 8 && c % 2 == 0) begin
            if (instr_vld !== 1'b1 || opcode !== ops[c/2-1] || instr_pc !== 16'(c/2-1) || instr !== mem[c/2-1]) begin
               errors++;
               $display("FAIL prog_issue c=%0d: vld=%b op=%h ipc=%h, expected vld=1 op=%h ipc=%h",
                        c, instr_vld, opcode, instr_pc, ops[c/2-1], c/2-1);
            end
         end else if (c <= 8) begin
            if (instr_vld !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'(c/2)) begin
               errors++;
               $display("FAIL prog_fetch c=%0d: vld=%b req=%b addr=%h, expected vld=0 req=1 addr=%h",
                        c, instr_vld, imem_req, imem_addr, c/2);
            end
         end else begin
            if (halted !== 1'b1 || imem_req !== 1'b0 || instr_vld !== 1'b0 || imem_addr !== 16'h4) begin
               errors++;
               $display("FAIL prog_halt c=%0d: halted=%b req=%b vld=%b pc=%h, expected 1 0 0 0004",
                        c, halted, imem_req, instr_vld, imem_addr);
            end
         end
      end
   endtask

   task automatic test_wait();
      for (int i = 0; i < 5; i++) mem[i] = 16'h3000 + 16'(i);
      memLat = 3;
      doReset();
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         checks++;
         if (c % 5 == 0) begin
            if (instr_vld !== 1'b1 || imem_req !== 1'b0 || instr_pc !== 16'(c/5-1) || instr !== mem[c/5-1]) begin
               errors++;
               $display("FAIL wait_issue c=%0d: vld=%b req=%b ipc=%h, expected vld=1 req=0 ipc=%h",
                        c, instr_vld, imem_req, instr_pc, c/5-1);
            end
         end else begin
            if (instr_vld !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'(c/5)) begin
               errors++;
               $display("FAIL wait_req c=%0d: vld=%b req=%b addr=%h, expected vld=0 req=1 addr=%h",
                        c, instr_vld, imem_req, imem_addr, c/5);
            end
         end
      end
   endtask

   task automatic test_stall();
      logic got;
      mem[5] = 16'h1234;
      memLat = 0;
      doReset();
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         if (instr_vld && instr_pc == 16'h5) got = 1'b1;
      end
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL stall_reach: pc 0005 never issued, expected issue");
      end else begin
         stall = 1'b1;
         for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (instr_vld !== 1'b1 || instr !== 16'h1234 || opcode !== 4'h1 || instr_pc !== 16'h5 || imem_req !== 1'b0) begin
               errors++;
               $display("FAIL stall_hold k=%0d: vld=%b instr=%h op=%h ipc=%h req=%b, expected 1 1234 1 0005 0",
                        k, instr_vld, instr, opcode, instr_pc, imem_req);
            end
         end
         stall = 1'b0;
         @(negedge clk);
         checks++;
         if (instr_vld !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h6) begin
            errors++;
            $display("FAIL stall_release: vld=%b req=%b addr=%h, expected 0 1 0006", instr_vld, imem_req, imem_addr);
         end
      end
   endtask

   task automatic test_redirect_drop();
      logic got;
      mem[16'h40] = 16'h4040; mem[16'h60] = 16'h6060; mem[16'h80] = 16'h8080;
      memLat = 3;
      doReset();
      @(negedge clk);
      redirect = 1'b1; redirect_pc = 16'h0040;
      @(negedge clk);
      redirect = 1'b0;
      for (int k = 0; k < 3; k++) begin
         if (k > 0) @(negedge clk);
         checks++;
         if (imem_req !== 1'b1 || imem_addr !== 16'h0 || instr_vld !== 1'b0) begin
            errors++;
            $display("FAIL drop_hold k=%0d: req=%b addr=%h vld=%b, expected 1 0000 0", k, imem_req, imem_addr, instr_vld);
         end
      end
      @(negedge clk);
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 16'h0040 || instr_vld !== 1'b0) begin
         errors++;
         $display("FAIL drop_target: req=%b addr=%h vld=%b, expected 1 0040 0", imem_req, imem_addr, instr_vld);
      end
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (instr_vld) got = 1'b1;
      end
      checks++;
      if (!got || instr_pc !== 16'h0040 || instr !== 16'h4040) begin
         errors++;
         $display("FAIL drop_issue: got=%b ipc=%h instr=%h, expected 1 0040 4040", got, instr_pc, instr);
      end
      @(negedge clk);
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 16'h0041) begin
         errors++;
         $display("FAIL drop_next: req=%b addr=%h, expected 1 0041", imem_req, imem_addr);
      end
      redirect = 1'b1; redirect_pc = 16'h0060;
      @(negedge clk);
      redirect_pc = 16'h0080;
      @(negedge clk);
      redirect = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (instr_vld) got = 1'b1;
      end
      checks++;
      if (!got || instr_pc !== 16'h0080 || instr !== 16'h8080) begin
         errors++;
         $display("FAIL drop_retarget: got=%b ipc=%h instr=%h, expected 1 0080 8080", got, instr_pc, instr);
      end
   endtask

   task automatic test_redirect_hlt();
      logic got;
      mem[0] = 16'hF000; mem[16'h20] = 16'h5020; mem[16'hFFFF] = 16'h7FFF;
      memLat = 0;
      doReset();
      repeat (2) @(negedge clk);
      checks++;
      if (instr_vld !== 1'b1 || opcode !== 4'hF) begin
         errors++;
         $display("FAIL hlt_issue: vld=%b op=%h, expected 1 f", instr_vld, opcode);
      end
      redirect = 1'b1; redirect_pc = 16'h0020;
      @(negedge clk);
      redirect = 1'b0;
      checks++;
      if (instr_vld !== 1'b0 || halted !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h0020) begin
         errors++;
         $display("FAIL hlt_squash: vld=%b halted=%b req=%b addr=%h, expected 0 0 1 0020",
                  instr_vld, halted, imem_req, imem_addr);
      end
      @(negedge clk);
      checks++;
      if (instr_vld !== 1'b1 || instr_pc !== 16'h0020 || halted !== 1'b0) begin
         errors++;
         $display("FAIL hlt_resume: vld=%b ipc=%h halted=%b, expected 1 0020 0", instr_vld, instr_pc, halted);
      end
      redirect = 1'b1; redirect_pc = 16'hFFFF;
      @(negedge clk);
      redirect = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (instr_vld) got = 1'b1;
      end
      checks++;
      if (!got || instr_pc !== 16'hFFFF || pc_plus1 !== 16'h0000 || instr !== 16'h7FFF) begin
         errors++;
         $display("FAIL wrap_issue: got=%b ipc=%h p1=%h instr=%h, expected 1 ffff 0000 7fff",
                  got, instr_pc, pc_plus1, instr);
      end
      @(negedge clk);
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
         errors++;
         $display("FAIL wrap_fetch: req=%b addr=%h, expected 1 0000", imem_req, imem_addr);
      end
   endtask

   task automatic test_reset_mid();
      logic got;
      memLat = 3;
      doReset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if (imem_req !== 1'b0 || instr_vld !== 1'b0 || halted !== 1'b0 || instr !== 16'h0 || instr_pc !== 16'h0) begin
         errors++;
         $display("FAIL reset_mid_wait: req=%b vld=%b halted=%b instr=%h ipc=%h, expected all zero",
                  imem_req, instr_vld, halted, instr, instr_pc);
      end
      mem[0] = 16'hF000;
      memLat = 0;
      doReset();
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (halted) got = 1'b1;
      end
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL reset_mid_halt_reach: halted never rose, expected 1");
      end
      rst_n = 1'b0;
      #2;
      checks++;
      if (halted !== 1'b0 || imem_req !== 1'b0 || instr_vld !== 1'b0 || instr !== 16'h0 || opcode !== 4'h0 ||
          imem_addr !== 16'h0) begin
         errors++;
         $display("FAIL reset_mid_halt: halted=%b req=%b vld=%b instr=%h addr=%h, expected all zero",
                  halted, imem_req, instr_vld, instr, imem_addr);
      end
      mem[0] = 16'h9ABC;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 16'h0) begin
         errors++;
         $display("FAIL reset_restart: req=%b addr=%h, expected 1 0000", imem_req, imem_addr);
      end
      @(negedge clk);
      checks++;
      if (instr_vld !== 1'b1 || instr_pc !== 16'h0 || instr !== 16'h9ABC) begin
         errors++;
         $display("FAIL reset_restart_issue: vld=%b ipc=%h instr=%h, expected 1 0000 9abc", instr_vld, instr_pc, instr);
      end
   endtask

   initial begin
      errors      = 0;
      checks      = 0;
      memRand     = 1'b0;
      memLat      = 0;
      rst_n       = 1'b0;
      stall       = 1'b0;
      redirect    = 1'b0;
      redirect_pc = '0;
      for (int i = 0; i < 65536; i++) mem[i] = 16'h1000;
      test_reset();
      test_random();
      test_program();
      test_wait();
      test_stall();
      test_redirect_drop();
      test_redirect_hlt();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
